iu_digit_entry: RTL and testbench

Input unit for the eight-bit four-function calculator: collects decimal keypad digits, a sign toggle and an Enter key, and assembles a signed operand as 16-bit two's complement. It is the reverse path of the output unit: decimal digits in, binary word out. Its live `Value` feeds the output mux so the display echoes the entry. The latched `Operand` / `OperandValid` pair feeds the arithmetic unit.

---
 rtl/iu_digit_entry.sv | 196 +++++++++++++++++++
 tb/tb_iu_digit_entry.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/iu_digit_entry.sv
// iu_digit_entry: keypad input unit for the eight-bit calculator.
// Collects BCD digits, a sign toggle and Enter, and assembles a signed
// 16-bit two's-complement operand.
// Optional feature macro: IU_BACKSPACE_EN (enables the Back key).
module iu_digit_entry #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned MAXPOS = 127,
  parameter int unsigned MAXNEG = 128
) (
  input  logic        CLK,
  input  logic        Clear,
  input  logic        DigitValid,
  input  logic [3:0]  Digit,
  input  logic        Neg,
  input  logic        Back,
  input  logic        Enter,
  output logic [15:0] Value,
  output logic [15:0] Operand,
  output logic        OperandValid,
  output logic        Err,
  output logic        Entering
);

  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned MW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state, state_nx;
  logic [DIGITS-1:0][3:0] bcd, bcd_nx;
  logic [CW-1:0]          cnt, cnt_nx;
  logic                   neg, neg_nx;
  logic [MW-1:0]          mag, mag_nx;
  logic [MW-1:0]          value_nx, operand_nx;
  logic                   opv_nx, err_nx, entering_nx;

  logic                   fresh;
  logic [DIGITS-1:0][3:0] base_bcd;
  logic [CW-1:0]          base_cnt;
  logic                   base_neg;
  logic [MW-1:0]          base_mag, cand;
  logic                   dig_ok, neg_ok;
  logic                   act_enter, act_back, act_neg, act_dig;

`ifdef IU_BACKSPACE_EN
  logic [DIGITS-1:0][3:0] back_bcd;
  logic [CW-1:0]          back_cnt;
  logic [MW-1:0]          back_mag;
`else
  logic                   unused_back;
  assign unused_back = Back;
`endif

  // Key decode: fresh-entry base, shift-add candidate, accept tests, priority
  always_comb begin
    fresh     = (state != ENTRY);
    base_bcd  = fresh ? '0 : bcd;
    base_cnt  = fresh ? '0 : cnt;
    base_neg  = fresh ? 1'b0 : neg;
    base_mag  = fresh ? '0 : mag;
    cand      = (base_mag << 3) + (base_mag << 1) + MW'(Digit);
    dig_ok    = (Digit <= 4'd9) && (base_cnt < CW'(DIGITS)) &&
                (cand <= (base_neg ? MW'(MAXNEG) : MW'(MAXPOS)));
    // Toggled sign: currently negative becomes positive and vice versa
    neg_ok    = base_mag <= (base_neg ? MW'(MAXPOS) : MW'(MAXNEG));
    act_enter = Enter;
`ifdef IU_BACKSPACE_EN
    act_back  = !Enter && Back;
`else
    act_back  = 1'b0;
`endif
    act_neg   = !Enter && !act_back && Neg;
    act_dig   = !Enter && !act_back && !Neg && DigitValid;
  end

`ifdef IU_BACKSPACE_EN
  // Backspace: drop the ones digit and rebuild the magnitude from BCD
  always_comb begin
    back_bcd = '0;
    for (int i = 0; i < int'(DIGITS) - 1; i++) begin
      back_bcd[i] = bcd[i+1];
    end
    back_cnt = (cnt != '0) ? cnt - CW'(1) : cnt;
    back_mag = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      back_mag = (back_mag << 3) + (back_mag << 1) + MW'(back_bcd[i]);
    end
  end
`endif

  // FSM state register
  always_ff @(posedge CLK) begin
    if (Clear) state <= IDLE;
    else       state <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    if (act_enter) begin
      state_nx = DONE;
    end
`ifdef IU_BACKSPACE_EN
    else if (act_back) begin
      if (state == ENTRY) begin
        state_nx = ((back_mag == '0) && !neg) ? IDLE : ENTRY;
      end
    end
`endif
    else if (act_neg) begin
      if (neg_ok) state_nx = ENTRY;
    end else if (act_dig) begin
      if (dig_ok) state_nx = ENTRY;
    end
  end

  // Output / datapath next values; rejected keys leave entry state untouched
  always_comb begin
    bcd_nx     = bcd;
    cnt_nx     = cnt;
    neg_nx     = neg;
    mag_nx     = mag;
    operand_nx = Operand;
    opv_nx     = 1'b0;
    err_nx     = Err;
    if (act_enter) begin
      operand_nx = Value;
      opv_nx     = 1'b1;
      err_nx     = 1'b0;
    end
`ifdef IU_BACKSPACE_EN
    else if (act_back) begin
      if (state == ENTRY) begin
        bcd_nx = back_bcd;
        cnt_nx = back_cnt;
        mag_nx = back_mag;
      end
    end
`endif
    else if (act_neg) begin
      if (neg_ok) begin
        bcd_nx = base_bcd;
        cnt_nx = base_cnt;
        neg_nx = !base_neg;
        mag_nx = base_mag;
      end else begin
        err_nx = 1'b1;
      end
    end else if (act_dig) begin
      if (dig_ok) begin
        for (int i = 1; i < int'(DIGITS); i++) begin
          bcd_nx[i] = base_bcd[i-1];
        end
        bcd_nx[0] = Digit;
        // Leading zeros do not consume a digit slot
        cnt_nx = ((base_mag != '0) || (Digit != 4'd0)) ? base_cnt + CW'(1) : base_cnt;
        neg_nx = base_neg;
        mag_nx = cand;
      end else begin
        err_nx = 1'b1;
      end
    end
    value_nx    = neg_nx ? (~mag_nx + MW'(1)) : mag_nx;
    entering_nx = (state_nx == ENTRY);
  end

  // Entry state and registered outputs
  always_ff @(posedge CLK) begin
    if (Clear) begin
      bcd          <= '0;
      cnt          <= '0;
      neg          <= 1'b0;
      mag          <= '0;
      Value        <= '0;
      Operand      <= '0;
      OperandValid <= 1'b0;
      Err          <= 1'b0;
      Entering     <= 1'b0;
    end else begin
      bcd          <= bcd_nx;
      cnt          <= cnt_nx;
      neg          <= neg_nx;
      mag          <= mag_nx;
      Value        <= value_nx;
      Operand      <= operand_nx;
      OperandValid <= opv_nx;
      Err          <= err_nx;
      Entering     <= entering_nx;
    end
  end

endmodule

// File: tb/tb_iu_digit_entry.sv
// tb_iu_digit_entry: directed vector table plus a pulse-width sequence.
module tb_iu_digit_entry;

`ifdef IU_BACKSPACE_EN
  localparam bit BK = 1'b1;
`else
  localparam bit BK = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        Clear = 1'b0;
  logic        DigitValid = 1'b0;
  logic [3:0]  Digit = 4'd0;
  logic        Neg = 1'b0;
  logic        Back = 1'b0;
  logic        Enter = 1'b0;
  logic [15:0] Value;
  logic [15:0] Operand;
  logic        OperandValid;
  logic        Err;
  logic        Entering;

  int passed = 0;
  int total  = 0;

  iu_digit_entry #(.DIGITS(3), .MAXPOS(127), .MAXNEG(128)) dut (
    .CLK(CLK), .Clear(Clear), .DigitValid(DigitValid), .Digit(Digit),
    .Neg(Neg), .Back(Back), .Enter(Enter), .Value(Value),
    .Operand(Operand), .OperandValid(OperandValid), .Err(Err),
    .Entering(Entering)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] name;
    logic        clr, dv;
    logic [3:0]  d;
    logic        ng, bk, en;
    logic [15:0] v, op;
    logic        opv, err, ent;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [63:0] name, input logic clr, input logic dv,
                              input logic [3:0] d, input logic ng, input logic bk,
                              input logic en, input logic [15:0] v, input logic [15:0] op,
                              input logic opv, input logic err, input logic ent);
    vec_t r;
    r.name = name; r.clr = clr; r.dv = dv; r.d = d; r.ng = ng; r.bk = bk; r.en = en;
    r.v = v; r.op = op; r.opv = opv; r.err = err; r.ent = ent;
    return r;
  endfunction

  task automatic drive(input logic clr, input logic dv, input logic [3:0] d,
                       input logic ng, input logic bk, input logic en);
    @(negedge CLK);
    Clear = clr; DigitValid = dv; Digit = d; Neg = ng; Back = bk; Enter = en;
    @(posedge CLK);
    #1;
    Clear = 1'b0; DigitValid = 1'b0; Digit = 4'd0; Neg = 1'b0; Back = 1'b0; Enter = 1'b0;
  endtask

  task automatic check_vec(input vec_t t);
    drive(t.clr, t.dv, t.d, t.ng, t.bk, t.en);
    total++;
    if ({Value, Operand, OperandValid, Err, Entering} === {t.v, t.op, t.opv, t.err, t.ent}) begin
      passed++;
    end else begin
      $display("FAIL %s: got Value=%h Operand=%h OperandValid=%b Err=%b Entering=%b, want %h %h %b %b %b",
               t.name, Value, Operand, OperandValid, Err, Entering,
               t.v, t.op, t.opv, t.err, t.ent);
    end
  endtask

  initial begin
    int pulses;
    //                 name        clr dv d     ng bk en  Value    Operand  opv err ent
    vecs.push_back(mk("reset",    1, 0, 4'd0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("k1",       0, 1, 4'd1, 0, 0, 0, 16'h0001, 16'h0000, 0, 0, 1));
    vecs.push_back(mk("k2",       0, 1, 4'd2, 0, 0, 0, 16'h000C, 16'h0000, 0, 0, 1));
    vecs.push_back(mk("k7",       0, 1, 4'd7, 0, 0, 0, 16'h007F, 16'h0000, 0, 0, 1));
    vecs.push_back(mk("ent127",   0, 0, 4'd0, 0, 0, 1, 16'h007F, 16'h007F, 1, 0, 0));
    vecs.push_back(mk("idle1",    0, 0, 4'd0, 0, 0, 0, 16'h007F, 16'h007F, 0, 0, 0));
    vecs.push_back(mk("clr2",     1, 0, 4'd0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("k1b",      0, 1, 4'd1, 0, 0, 0, 16'h0001, 16'h0000, 0, 0, 1));
    vecs.push_back(mk("k2b",      0, 1, 4'd2, 0, 0, 0, 16'h000C, 16'h0000, 0, 0, 1));
    vecs.push_back(mk("k8rej",    0, 1, 4'd8, 0, 0, 0, 16'h000C, 16'h0000, 0, 1, 1));
    vecs.push_back(mk("neg12",    0, 0, 4'd0, 1, 0, 0, 16'hFFF4, 16'h0000, 0, 1, 1));
    vecs.push_back(mk("k8m128",   0, 1, 4'd8, 0, 0, 0, 16'hFF80, 16'h0000, 0, 1, 1));
    vecs.push_back(mk("negrej",   0, 0, 4'd0, 1, 0, 0, 16'hFF80, 16'h0000, 0, 1, 1));
    vecs.push_back(mk("entm128",  0, 0, 4'd0, 0, 0, 1, 16'hFF80, 16'hFF80, 1, 0, 0));
    vecs.push_back(mk("reent",    0, 0, 4'd0, 0, 0, 1, 16'hFF80, 16'hFF80, 1, 0, 0));
    vecs.push_back(mk("k0fresh",  0, 1, 4'd0, 0, 0, 0, 16'h0000, 16'hFF80, 0, 0, 1));
    vecs.push_back(mk("k0lead",   0, 1, 4'd0, 0, 0, 0, 16'h0000, 16'hFF80, 0, 0, 1));
    vecs.push_back(mk("k4",       0, 1, 4'd4, 0, 0, 0, 16'h0004, 16'hFF80, 0, 0, 1));
    vecs.push_back(mk("k5",       0, 1, 4'd5, 0, 0, 0, 16'h002D, 16'hFF80, 0, 0, 1));
    vecs.push_back(mk("k9rej",    0, 1, 4'd9, 0, 0, 0, 16'h002D, 16'hFF80, 0, 1, 1));
    vecs.push_back(mk("kArej",    0, 1, 4'hA, 0, 0, 0, 16'h002D, 16'hFF80, 0, 1, 1));
    vecs.push_back(mk("ent45",    0, 0, 4'd0, 0, 0, 1, 16'h002D, 16'h002D, 1, 0, 0));
    vecs.push_back(mk("k5new",    0, 1, 4'd5, 0, 0, 0, 16'h0005, 16'h002D, 0, 0, 1));
    vecs.push_back(mk("entdig",   0, 1, 4'd7, 0, 0, 1, 16'h0005, 16'h0005, 1, 0, 0));
    vecs.push_back(mk("k3new",    0, 1, 4'd3, 0, 0, 0, 16'h0003, 16'h0005, 0, 0, 1));
    vecs.push_back(mk("clr3",     1, 0, 4'd0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("bk_k1",    0, 1, 4'd1, 0, 0, 0, 16'h0001, 16'h0000, 0, 0, 1));
    vecs.push_back(mk("bk_k2",    0, 1, 4'd2, 0, 0, 0, 16'h000C, 16'h0000, 0, 0, 1));
    vecs.push_back(mk("back1",    0, 0, 4'd0, 0, 1, 0, BK ? 16'h0001 : 16'h000C, 16'h0000, 0, 0, 1));
    vecs.push_back(mk("back2",    0, 0, 4'd0, 0, 1, 0, BK ? 16'h0000 : 16'h000C, 16'h0000, 0, 0, BK ? 1'b0 : 1'b1));
    vecs.push_back(mk("backneg",  0, 0, 4'd0, 1, 1, 0, BK ? 16'h0000 : 16'hFFF4, 16'h0000, 0, 0, BK ? 1'b0 : 1'b1));
    vecs.push_back(mk("k4mid",    0, 1, 4'd4, 0, 0, 0, BK ? 16'h0004 : 16'hFF84, 16'h0000, 0, 0, 1));
    vecs.push_back(mk("clrent",   1, 1, 4'd6, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("idle2",    0, 0, 4'd0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("negidle",  0, 0, 4'd0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 1));
    vecs.push_back(mk("nk1",      0, 1, 4'd1, 0, 0, 0, 16'hFFFF, 16'h0000, 0, 0, 1));
    vecs.push_back(mk("nk0",      0, 1, 4'd0, 0, 0, 0, 16'hFFF6, 16'h0000, 0, 0, 1));
    vecs.push_back(mk("nk00",     0, 1, 4'd0, 0, 0, 0, 16'hFF9C, 16'h0000, 0, 0, 1));
    vecs.push_back(mk("cntrej",   0, 1, 4'd0, 0, 0, 0, 16'hFF9C, 16'h0000, 0, 1, 1));
    vecs.push_back(mk("entm100",  0, 0, 4'd0, 0, 0, 1, 16'hFF9C, 16'hFF9C, 1, 0, 0));
    vecs.push_back(mk("negdig",   0, 1, 4'd5, 1, 0, 0, 16'h0000, 16'hFF9C, 0, 0, 1));
    vecs.push_back(mk("negk0",    0, 1, 4'd0, 0, 0, 0, 16'h0000, 16'hFF9C, 0, 0, 1));
    vecs.push_back(mk("kFrej",    0, 1, 4'hF, 0, 0, 0, 16'h0000, 16'hFF9C, 0, 1, 1));

    foreach (vecs[i]) check_vec(vecs[i]);

    // OperandValid must be exactly one cycle wide after a back-to-back key burst
    drive(1, 0, 4'd0, 0, 0, 0);
    drive(0, 1, 4'd9, 0, 0, 0);
    drive(0, 1, 4'd9, 0, 0, 0);
    drive(0, 0, 4'd0, 0, 0, 1);
    pulses = int'(OperandValid);
    total++;
    if (Operand === 16'h0063) passed++;
    else $display("FAIL seq_operand: got %h want 0063", Operand);
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK);
      #1;
      pulses += int'(OperandValid);
    end
    total++;
    if (pulses == 1) passed++;
    else $display("FAIL seq_pulse_width: got %0d pulse cycles want 1", pulses);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
